// File: rtl/sc_pkg.sv
// sc_pkg -- shared definitions for the stochastic bitstream decoder.
//   sc_state_t    : conversion FSM encoding (IDLE / COUNT / DONE)
//   SC_RES_EXTRA  : extra result bits beyond WIDTH. One bit holds the
//                   full count 2^WIDTH and one more bit is the sign in
//                   the bipolar build.
package sc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_DONE  = 2'd2
   } sc_state_t;

   localparam int SC_RES_EXTRA = 2;

endpackage : sc_pkg

// File: rtl/sc_ones_counter.sv
// sc_ones_counter -- ones and sample accumulation for one conversion window.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_clr           synchronous clear of both counters (new window)
//   i_acc           accept the current sample this cycle
//   i_bit           sample value
//   o_ones          ones seen so far in the window (WIDTH+1 bits)
//   o_samples       samples accepted so far in the window (WIDTH+1 bits)
//   o_last          the sample accepted this cycle is number 2^WIDTH
module sc_ones_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_acc,
   input  logic             i_bit,
   output logic [WIDTH:0]   o_ones,
   output logic [WIDTH:0]   o_samples,
   output logic             o_last
);

   // Sample count before the final sample is accepted: 2^WIDTH - 1.
   localparam logic [WIDTH:0] LP_LAST = {1'b0, {WIDTH{1'b1}}};

   logic [WIDTH:0] r_ones;
   logic [WIDTH:0] r_samples;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ones    <= '0;
         r_samples <= '0;
      end else if (i_clr) begin
         r_ones    <= '0;
         r_samples <= '0;
      end else if (i_acc) begin
         r_samples <= r_samples + 1'b1;
         r_ones    <= r_ones + {{WIDTH{1'b0}}, i_bit};
      end
   end

   assign o_ones    = r_ones;
   assign o_samples = r_samples;
   assign o_last    = i_acc && (r_samples == LP_LAST);

endmodule : sc_ones_counter

// File: rtl/sc_stream_decoder.sv
// sc_stream_decoder -- converts a stochastic bitstream into a binary
// estimate by counting ones over a window of 2^WIDTH accepted samples.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   start      begin a new window (ignored while counting)
//   clear      abort the window in progress, result untouched
//   bit_in     stream sample, qualified by bit_en
//   busy       high in COUNT
//   done       one-cycle pulse when result is updated
//   result     last completed window, WIDTH+2 bits
// Build option: define SC_BIPOLAR_DECODE_EN for result = 2*ones - 2^WIDTH
// (two's complement); otherwise result = ones, zero-extended.
module sc_stream_decoder
   import sc_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          clear,
   input  logic                          bit_in,
   input  logic                          bit_en,
   output logic                          busy,
   output logic                          done,
   output logic [WIDTH+SC_RES_EXTRA-1:0] result
);

   localparam int RW = WIDTH + SC_RES_EXTRA;

   sc_state_t        r_state;
   sc_state_t        w_state_nxt;
   logic             w_clr_cnt;
   logic             w_load;
   logic             w_acc;
   logic             w_last;
   logic [WIDTH:0]   w_ones;
   logic [WIDTH:0]   w_samples;
   logic [WIDTH:0]   w_ones_fin;
   logic [RW-1:0]    w_res_val;
   logic [RW-1:0]    r_result;

   // A clear on the same cycle blocks acceptance, so a final sample
   // coinciding with clear never completes the window.
   assign w_acc = (r_state == ST_COUNT) && bit_en && !clear;

   sc_ones_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (w_clr_cnt),
      .i_acc     (w_acc),
      .i_bit     (bit_in),
      .o_ones    (w_ones),
      .o_samples (w_samples),
      .o_last    (w_last)
   );

   // Count including the final sample, which lands in the counter on
   // the same edge the result is loaded.
   assign w_ones_fin = w_ones + {{WIDTH{1'b0}}, bit_in};

`ifdef SC_BIPOLAR_DECODE_EN
   localparam logic [RW-1:0] LP_HALF = {2'b01, {WIDTH{1'b0}}};
   assign w_res_val = {w_ones_fin, 1'b0} - LP_HALF;
`else
   assign w_res_val = {1'b0, w_ones_fin};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_clr_cnt   = 1'b0;
      w_load      = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_COUNT;
               w_clr_cnt   = 1'b1;
            end
         end
         ST_COUNT: begin
            if (clear) begin
               w_state_nxt = ST_IDLE;
            end else if (w_last) begin
               w_state_nxt = ST_DONE;
               w_load      = 1'b1;
            end
         end
         ST_DONE: begin
            if (start) begin
               w_state_nxt = ST_COUNT;
               w_clr_cnt   = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_result <= '0;
      end else if (w_load) begin
         r_result <= w_res_val;
      end
   end

   assign busy   = (r_state == ST_COUNT);
   assign done   = (r_state == ST_DONE);
   assign result = r_result;

endmodule : sc_stream_decoder
